// File: rtl/isr_pkg.sv
// Shared constants and state encoding for the integer square-root engine.
// The collector and the result serializer use the same definitions.
package isr_pkg;

    // Radicand width (must be even) and the resulting root width
    localparam int DATA_WID = 256;
    localparam int ROOT_WID = DATA_WID / 2;

    // Control state encoding
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } isr_state_t;

endpackage

// File: rtl/isr_step.sv
// One restoring digit-by-digit square-root step: brings two radicand bits
// into the partial remainder and decides the next root bit.
module isr_step #(
    parameter int ROOT_WID = isr_pkg::ROOT_WID
) (
    input  logic [ROOT_WID:0]   w,
    input  logic [ROOT_WID-1:0] r,
    input  logic [1:0]          bits,
    output logic [ROOT_WID:0]   w_next,
    output logic [ROOT_WID-1:0] r_next
);

    // Extended remainder and trial value share one comparator/subtractor width
    logic [ROOT_WID+2:0] t;
    logic [ROOT_WID+2:0] q;
    logic                ge;

    // Trial subtraction: accept the digit when the trial fits in the remainder.
    // The partial remainder never needs more than ROOT_WID+1 bits, so the
    // narrowing cast below discards only zero bits.
    always_comb begin
        t      = {w, bits};
        q      = {1'b0, r, 2'b01};
        ge     = (t >= q);
        w_next = (ROOT_WID + 1)'(ge ? (t - q) : t);
        r_next = {r[ROOT_WID-2:0], ge};
    end

endmodule

// File: rtl/isr_core.sv
// Iterative integer square-root engine. A rising edge on calcen (while idle
// and re-armed by collector activity) captures the radicand; two radicand
// bits are retired per cycle and done pulses for one cycle with the results.
module isr_core #(
    parameter  int DATA_WID = isr_pkg::DATA_WID,
    localparam int ROOT_WID = DATA_WID / 2,
    localparam int CNT_WID  = $clog2(ROOT_WID)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [DATA_WID-1:0] a,
    input  logic                clken,
    input  logic                calcen,
    output logic                busy,
    output logic                done,
    output logic [ROOT_WID-1:0] root,
    output logic [ROOT_WID:0]   rem
);

    import isr_pkg::*;

    localparam logic [CNT_WID-1:0] LAST_CNT = CNT_WID'(ROOT_WID - 1);

    isr_state_t          state;
    logic [DATA_WID-1:0] sr;
    logic [ROOT_WID-1:0] r_work;
    logic [ROOT_WID:0]   w_work;
    logic [CNT_WID-1:0]  cnt;
    logic                calcen_d;
    logic                done_seen;
    logic                armed;

    logic [ROOT_WID-1:0] r_next;
    logic [ROOT_WID:0]   w_next;
    logic                start;

    // Datapath: one digit step on the top two radicand bits
    isr_step #(
        .ROOT_WID (ROOT_WID)
    ) u_step (
        .w      (w_work),
        .r      (r_work),
        .bits   (sr[DATA_WID-1 -: 2]),
        .w_next (w_next),
        .r_next (r_next)
    );

    // Start only on a genuine calcen rising edge, seen while idle, re-armed
    // by collector activity, and not on the very first clock after reset
    // (armed keeps a level already high at reset release from looking like an edge)
    always_comb begin
        start = calcen && !calcen_d && armed && (state == IDLE) && !done_seen;
    end

    // Control FSM, iteration counter, edge detect and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            sr        <= '0;
            r_work    <= '0;
            w_work    <= '0;
            cnt       <= '0;
            calcen_d  <= 1'b0;
            done_seen <= 1'b0;
            armed     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            root      <= '0;
            rem       <= '0;
        end else begin
            calcen_d <= calcen;
            armed    <= 1'b1;
            done     <= 1'b0;
            case (state)
                IDLE: begin
                    // New operand arriving re-arms the trigger
                    if (clken) begin
                        done_seen <= 1'b0;
                    end
                    if (start) begin
                        sr     <= a;
                        r_work <= '0;
                        w_work <= '0;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        state  <= CALC;
                    end
                end
                CALC: begin
                    sr     <= sr << 2;
                    r_work <= r_next;
                    w_work <= w_next;
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST_CNT) begin
                        root  <= r_next;
                        rem   <= w_next;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done_seen <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_isr_core.sv
// Self-checking bench for isr_core: directed and random radicands against a
// multiply-based reference square root, plus trigger and reset scenarios.
module tb_isr_core;

    localparam int DW  = 256;
    localparam int RW  = DW / 2;
    localparam int LAT = RW + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          clken;
    logic          calcen;
    logic [DW-1:0] a;
    logic          busy;
    logic          done;
    logic [RW-1:0] root;
    logic [RW:0]   rem;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    isr_core #(
        .DATA_WID (DW)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .a      (a),
        .clken  (clken),
        .calcen (calcen),
        .busy   (busy),
        .done   (done),
        .root   (root),
        .rem    (rem)
    );

    // Reference: largest root with root*root <= v, found bit by bit with a multiply
    task automatic model(input logic [DW-1:0] v, output logic [RW-1:0] rt, output logic [RW:0] rm);
        logic [2*DW-1:0] cand;
        logic [2*DW-1:0] sq;
        logic [2*DW-1:0] vv;
        vv   = {{DW{1'b0}}, v};
        cand = '0;
        for (int b = RW - 1; b >= 0; b--) begin
            sq = (cand | ((2*DW)'(1) << b)) * (cand | ((2*DW)'(1) << b));
            if (sq <= vv) cand = cand | ((2*DW)'(1) << b);
        end
        rt = cand[RW-1:0];
        sq = cand * cand;
        rm = (RW + 1)'(vv - sq);
    endtask

    function automatic logic [DW-1:0] rand_wide();
        logic [DW-1:0] v;
        for (int i = 0; i < DW / 32; i++) v = {v[DW-33:0], 32'($urandom)};
        return v >> $urandom_range(0, DW - 1);
    endfunction

    // Drive one operand: clken pulse, calcen low->high, then wait for done (bounded)
    task automatic run_op(input logic [DW-1:0] v, output int lat, output int bcnt,
                          output bit got, output bit changed,
                          output logic [RW-1:0] r_o, output logic [RW:0] m_o);
        logic [RW-1:0] r0;
        logic [RW:0]   m0;
        @(negedge clk);
        calcen = 1'b0;
        clken  = 1'b1;
        a      = v;
        @(negedge clk);
        clken = 1'b0;
        @(negedge clk);
        calcen  = 1'b1;
        r0      = root;
        m0      = rem;
        lat     = 0;
        bcnt    = 0;
        got     = 1'b0;
        changed = 1'b0;
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge clk);
            lat++;
            if (busy) bcnt++;
            if (done) got = 1'b1;
            else if (root !== r0 || rem !== m0) changed = 1'b1;
        end
        r_o = root;
        m_o = rem;
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        clken  = 1'b0;
        calcen = 1'b0;
        a      = '0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({busy, done} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_flags busy=%0b done=%0b required 0 0", busy, done);
        end
        n_checks++;
        if (root !== '0 || rem !== '0) begin
            n_fail++;
            $display("FAIL reset_results root=%h rem=%h required 0 0", root, rem);
        end
        rst = 1'b0;
        @(negedge clk);
        $display("reset: busy=%0b done=%0b root=%h rem=%h", busy, done, root, rem);
    endtask

    task automatic test_directed();
        logic [DW-1:0] vals [6];
        logic [RW-1:0] er   [6];
        logic [RW:0]   em   [6];
        int lat, bcnt;
        bit got, chg;
        logic [RW-1:0] r_o;
        logic [RW:0]   m_o;
        vals[0] = DW'(144); er[0] = RW'(12);  em[0] = '0;
        vals[1] = DW'(145); er[1] = RW'(12);  em[1] = (RW + 1)'(1);
        vals[2] = '0;       er[2] = '0;       em[2] = '0;
        vals[3] = DW'(1);   er[3] = RW'(1);   em[3] = '0;
        vals[4] = {DW{1'b1}}; er[4] = {RW{1'b1}}; em[4] = {{RW{1'b1}}, 1'b0};
        vals[5] = DW'(1) << 254; er[5] = RW'(1) << 127; em[5] = '0;
        for (int k = 0; k < 6; k++) begin
            run_op(vals[k], lat, bcnt, got, chg, r_o, m_o);
            $display("directed a=%h lat=%0d busy_cycles=%0d root=%h rem=%h", vals[k], lat, bcnt, r_o, m_o);
            n_checks++;
            if (!got || lat != LAT) begin
                n_fail++;
                $display("FAIL directed_latency case %0d got_done=%0b lat=%0d required %0d", k, got, lat, LAT);
            end
            n_checks++;
            if (bcnt != RW) begin
                n_fail++;
                $display("FAIL directed_busy case %0d busy_cycles=%0d required %0d", k, bcnt, RW);
            end
            n_checks++;
            if (r_o !== er[k] || m_o !== em[k]) begin
                n_fail++;
                $display("FAIL directed_result case %0d root=%h rem=%h required %h %h", k, r_o, m_o, er[k], em[k]);
            end
        end
    endtask

    task automatic test_hold_level();
        int dones = 0, busies = 0;
        // calcen is still high from the previous operand
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (done) dones++;
            if (busy) busies++;
        end
        $display("hold_level: extra_done=%0d busy_cycles=%0d", dones, busies);
        n_checks++;
        if (dones != 0 || busies != 0) begin
            n_fail++;
            $display("FAIL hold_level extra_done=%0d busy_cycles=%0d required 0 0", dones, busies);
        end
    endtask

    task automatic test_random();
        logic [DW-1:0] v;
        logic [RW-1:0] er, r_o;
        logic [RW:0]   em, m_o;
        int lat, bcnt;
        bit got, chg;
        for (int k = 0; k < 8; k++) begin
            v = rand_wide();
            model(v, er, em);
            run_op(v, lat, bcnt, got, chg, r_o, m_o);
            $display("random a=%h lat=%0d root=%h rem=%h", v, lat, r_o, m_o);
            n_checks++;
            if (!got || lat != LAT || r_o !== er || m_o !== em) begin
                n_fail++;
                $display("FAIL random got_done=%0b lat=%0d root=%h rem=%h required lat %0d %h %h",
                         got, lat, r_o, m_o, LAT, er, em);
            end
        end
    endtask

    task automatic test_toggle_during_calc();
        logic [DW-1:0] v;
        logic [RW-1:0] er, r_o;
        logic [RW:0]   em, m_o;
        int dones = 0, first_lat = 0;
        v = rand_wide() | (DW'(1) << 200);
        model(v, er, em);
        r_o = '0;
        m_o = '0;
        @(negedge clk);
        calcen = 1'b0;
        clken  = 1'b1;
        a      = v;
        @(negedge clk);
        clken = 1'b0;
        @(negedge clk);
        calcen = 1'b1;
        for (int i = 1; i <= 400; i++) begin
            @(negedge clk);
            if (i == 40) a = ~v;
            if (i == 50) calcen = 1'b0;
            if (i == 52) calcen = 1'b1;
            if (done) begin
                dones++;
                if (dones == 1) begin
                    first_lat = i;
                    r_o = root;
                    m_o = rem;
                end
            end
        end
        a = v;
        $display("toggle: dones=%0d lat=%0d root=%h rem=%h", dones, first_lat, r_o, m_o);
        n_checks++;
        if (dones != 1 || first_lat != LAT) begin
            n_fail++;
            $display("FAIL toggle_done dones=%0d lat=%0d required 1 %0d", dones, first_lat, LAT);
        end
        n_checks++;
        if (r_o !== er || m_o !== em) begin
            n_fail++;
            $display("FAIL toggle_result root=%h rem=%h required %h %h", r_o, m_o, er, em);
        end
    endtask

    task automatic test_reset_mid_calc();
        logic [DW-1:0] v;
        logic [RW-1:0] er, r_o;
        logic [RW:0]   em, m_o;
        int acts = 0, lat, bcnt;
        bit got, chg;
        @(negedge clk);
        calcen = 1'b0;
        clken  = 1'b1;
        a      = rand_wide();
        @(negedge clk);
        clken = 1'b0;
        @(negedge clk);
        calcen = 1'b1;
        repeat (60) @(negedge clk);
        rst = 1'b1;
        #1;
        $display("reset_mid: busy=%0b done=%0b root=%h rem=%h", busy, done, root, rem);
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || root !== '0 || rem !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_async busy=%0b done=%0b root=%h rem=%h required all 0", busy, done, root, rem);
        end
        @(negedge clk);
        rst = 1'b0;
        // calcen stays high through and after reset release
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (busy || done) acts++;
        end
        n_checks++;
        if (acts != 0) begin
            n_fail++;
            $display("FAIL reset_level_no_start active_cycles=%0d required 0", acts);
        end
        v = rand_wide();
        model(v, er, em);
        run_op(v, lat, bcnt, got, chg, r_o, m_o);
        $display("after_reset a=%h lat=%0d root=%h rem=%h", v, lat, r_o, m_o);
        n_checks++;
        if (!got || lat != LAT || r_o !== er || m_o !== em) begin
            n_fail++;
            $display("FAIL after_reset got_done=%0b lat=%0d root=%h rem=%h required lat %0d %h %h",
                     got, lat, r_o, m_o, LAT, er, em);
        end
    endtask

    task automatic test_back_to_back();
        logic [RW-1:0] r_o;
        logic [RW:0]   m_o;
        int lat, bcnt;
        bit got, chg;
        run_op(DW'(99), lat, bcnt, got, chg, r_o, m_o);
        $display("b2b a=99 lat=%0d root=%0d rem=%0d", lat, r_o, m_o);
        n_checks++;
        if (!got || r_o !== RW'(9) || m_o !== (RW + 1)'(18)) begin
            n_fail++;
            $display("FAIL b2b_first got_done=%0b root=%0d rem=%0d required 9 18", got, r_o, m_o);
        end
        run_op(DW'(100), lat, bcnt, got, chg, r_o, m_o);
        $display("b2b a=100 lat=%0d root=%0d rem=%0d held=%0b", lat, r_o, m_o, !chg);
        n_checks++;
        if (chg) begin
            n_fail++;
            $display("FAIL b2b_hold results_changed=%0b required 0", chg);
        end
        n_checks++;
        if (!got || lat != LAT || r_o !== RW'(10) || m_o !== '0) begin
            n_fail++;
            $display("FAIL b2b_second got_done=%0b lat=%0d root=%0d rem=%0d required lat %0d 10 0",
                     got, lat, r_o, m_o, LAT);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_hold_level();
        test_random();
        test_toggle_during_calc();
        test_reset_mid_calc();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/isr_core.md
Name: isr_core

Overview:
- Iterative integer square-root engine, directly downstream of the packet collector.
- Consumes the assembled 256-bit radicand `a` and the `calcen` level from the collector.
- Computes floor(sqrt(a)) and the remainder using the restoring digit-by-digit method, 2 radicand bits per cycle.
- Raises a one-cycle `done` pulse when the results are ready for the result serializer.

Parameters:
- DATA_WID, 256, radicand width; must be even.
- ROOT_WID, DATA_WID/2 (derived localparam, not overridable), root width.
- CNT_WID, $clog2(ROOT_WID) (derived localparam), iteration counter width.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  asynchronous active-high reset
- a  input  DATA_WID  radicand from collector; sampled only on start
- clken  input  1  collector packet-activity flag; when high in IDLE, clears `done_seen` (arms next start)
- calcen  input  1  collector "operand complete" level; start trigger is its rising edge
- busy  output  1  high while iterating
- done  output  1  one-cycle pulse, results valid
- root  output  ROOT_WID  floor(sqrt(a)), held until next start
- rem  output  ROOT_WID+1  a - root*root, held until next start

Behaviour:
- Reset: asynchronous and active-high; all flops cleared immediately on rst assertion.
  - busy=0, done=0, root=0, rem=0, state=IDLE, calcen_d=0, done_seen=0.
- Start condition, evaluated every cycle: calcen=1 && calcen_d=0 && state==IDLE && done_seen==0.
  - calcen_d is calcen registered.
  - The collector holds calcen high after the last packet; only the edge triggers.
  - A level held high never re-triggers.
- States:
  - IDLE --start--> CALC
  - CALC --(cnt==ROOT_WID-1)--> DONE
  - DONE --> IDLE (unconditional, 1 cycle)
- Start cycle N:
  - Load shift register sr <= a.
  - Working root r <= 0; working remainder w <= 0; cnt <= 0; busy <= 1.
  - Outputs root/rem keep their previous values.
- Each CALC cycle:
  - Form t = {w, sr[DATA_WID-1:DATA_WID-2]}, width ROOT_WID+3.
  - Form trial q = {r, 2'b01}.
  - If t >= q: w <= t-q, r <= {r,1}. Else: w <= t, r <= {r,0}.
  - sr <<= 2; cnt++.
  - w is never wider than ROOT_WID+1 bits. Truncating the result after the subtraction loses nothing.
- Latency: CALC occupies cycles N+1..N+ROOT_WID (128 cycles).
  - On the last CALC edge, root/rem are loaded from the final r/w.
  - busy drops and done=1 during cycle N+ROOT_WID+1 (DONE state).
  - Start-edge to done = 129 cycles.
- done is high for exactly one cycle. done_seen is set in DONE. It is cleared when clken=1 while in IDLE, i.e. the next operand begins arriving.
- calcen edge during CALC or DONE: ignored, no queuing. calcen_d still tracks, so a level held across DONE does not start a new computation.
- `a` changing during CALC: no effect, since the operand was captured at start.
- rst asserted mid-CALC: computation abandoned, all outputs zero, no done.
  - After rst release, a calcen already high does not start a computation (calcen_d reset to 0 but first-cycle edge suppressed: calcen_d loads calcen on the first post-reset clock before start is evaluated; implement with a 1-cycle post-reset guard flop).
- Arithmetic: unsigned throughout; one ROOT_WID+3-bit comparator/subtractor; no multipliers.

Decomposition:
- Shared package isr_pkg:
  - DATA_WID and ROOT_WID constants.
  - State encoding enum (IDLE=2'd0, CALC=2'd1, DONE=2'd2).
  - These are reused by the collector and the result serializer.
- One natural sub-module: isr_step, combinational (w, r, two radicand bits) -> (w_next, r_next). Keeps the datapath separately testable.
- Control FSM, counter and edge detect stay in isr_core.

Test Plan:
- a=144, pulse clken then raise calcen -> done exactly 129 cycles after the edge; root=12, rem=0; busy high for 128 cycles.
- a=145 -> root=12, rem=1. a=0 -> root=0, rem=0. a=1 -> root=1, rem=0.
- a=2^256-1 -> root=2^128-1, rem=2^129-2 (exercises full rem width). a=2^254 -> root=2^127, rem=0.
- Hold calcen high 400 cycles after one edge -> exactly one done pulse. Toggle calcen at cycle 50 of CALC -> ignored, result unchanged.
- Assert rst at CALC cycle 60 -> busy, done, root and rem go 0 asynchronously; no done follows; a fresh clken + calcen edge then computes correctly.
- Back-to-back operands 99 then 100 with clken between -> root 9 rem 18, then root 10 rem 0; root/rem stable between the two done pulses.
